clk_freq_meter: RTL and testbench

CLK_FREQ_METER -- requirements
Module: clk_freq_meter

---
 rtl/clk_freq_meter.sv | 144 ++++++++++++++
 tb/tb_clk_freq_meter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - gated edge counter measuring a clock under test
// Counts synchronized rising edges of sig_in over a fixed window of clk cycles.
module clk_freq_meter #(
   parameter int GATE_CYCLES = 50_000,
   parameter int CNT_WIDTH   = 24,
   parameter int LO_LIMIT    = 0,
   parameter int HI_LIMIT    = 2**24 - 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] edge_cnt,
   output logic                 cnt_valid,
   output logic                 freq_ok,
   output logic                 no_clk,
   output logic                 busy
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARM     = 2'd1;
   localparam logic [1:0] S_MEASURE = 2'd2;
   localparam logic [1:0] S_REPORT  = 2'd3;

   localparam logic [23:0]          GATE_LAST = 24'(GATE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] LO_T      = CNT_WIDTH'(LO_LIMIT);
   localparam logic [CNT_WIDTH-1:0] HI_T      = CNT_WIDTH'(HI_LIMIT);
   localparam logic [CNT_WIDTH-1:0] SPAN      = HI_T - LO_T;
   localparam logic                 LIMITS_OK = (LO_T <= HI_T);

   logic [1:0]           state_q, state_d;
   logic                 sync1_q, sync2_q, prev_q;
   logic [23:0]          gate_q, gate_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 sat_q, sat_d;
   logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic                 cnt_valid_q, cnt_valid_d;
   logic                 freq_ok_q, freq_ok_d;
   logic                 no_clk_q, no_clk_d;

   logic                 rise;
   logic [CNT_WIDTH-1:0] meas_cnt;
   logic                 meas_sat;
   logic                 in_range;

   assign rise = sync2_q & ~prev_q;

   // Count including this cycle's edge, so the last MEASURE cycle is not lost.
   always_comb begin
      meas_cnt = cnt_q;
      meas_sat = sat_q;
      if (rise) begin
         if (cnt_q == CNT_MAX) meas_sat = 1'b1;
         else                  meas_cnt = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Offset compare: lo <= x <= hi  <=>  (x - lo) <= (hi - lo), unsigned.
   assign in_range = LIMITS_OK && ((meas_cnt - LO_T) <= SPAN);

   always_comb begin
      state_d     = state_q;
      gate_d      = gate_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      edge_cnt_d  = edge_cnt_q;
      freq_ok_d   = freq_ok_q;
      no_clk_d    = no_clk_q;
      cnt_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) state_d = S_ARM;
         end
         S_ARM: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               gate_d  = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = S_MEASURE;
            end
         end
         S_MEASURE: begin
            if (!en) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = meas_cnt;
               sat_d = meas_sat;
               if (gate_q == GATE_LAST) begin
                  // Results land on the edge into REPORT so they are valid alongside cnt_valid.
                  state_d     = S_REPORT;
                  edge_cnt_d  = meas_cnt;
                  no_clk_d    = (meas_cnt == '0);
                  freq_ok_d   = in_range && !meas_sat;
                  cnt_valid_d = 1'b1;
               end else begin
                  gate_d = gate_q + 24'd1;
               end
            end
         end
         S_REPORT: begin
            state_d = en ? S_ARM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         gate_q      <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         edge_cnt_q  <= '0;
         cnt_valid_q <= 1'b0;
         freq_ok_q   <= 1'b0;
         no_clk_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sig_in;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         gate_q      <= gate_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         edge_cnt_q  <= edge_cnt_d;
         cnt_valid_q <= cnt_valid_d;
         freq_ok_q   <= freq_ok_d;
         no_clk_q    <= no_clk_d;
      end
   end

   assign edge_cnt  = edge_cnt_q;
   assign cnt_valid = cnt_valid_q;
   assign freq_ok   = freq_ok_q;
   assign no_clk    = no_clk_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - directed self-checking bench for clk_freq_meter
// Three instances: nominal limits, 4-bit saturating counter, 700-cycle window.
module tb_clk_freq_meter;

   logic clk = 1'b0;
   logic rst;
   logic en_a, en_b, en_c;
   logic sig_a, sig_c;
   logic sig_a_run;

   logic [23:0] a_cnt, c_cnt;
   logic [3:0]  b_cnt;
   logic a_valid, a_ok, a_noclk, a_busy;
   logic b_valid, b_ok, b_noclk, b_busy;
   logic c_valid, c_ok, c_noclk, c_busy;

   int tests_run;
   int tests_failed;
   int n;
   logic seen;

   clk_freq_meter #(.GATE_CYCLES(1000), .CNT_WIDTH(24), .LO_LIMIT(90), .HI_LIMIT(110)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_a),
      .edge_cnt(a_cnt), .cnt_valid(a_valid), .freq_ok(a_ok), .no_clk(a_noclk), .busy(a_busy));

   clk_freq_meter #(.GATE_CYCLES(1000), .CNT_WIDTH(4), .LO_LIMIT(90), .HI_LIMIT(110)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_a),
      .edge_cnt(b_cnt), .cnt_valid(b_valid), .freq_ok(b_ok), .no_clk(b_noclk), .busy(b_busy));

   clk_freq_meter #(.GATE_CYCLES(700), .CNT_WIDTH(24), .LO_LIMIT(90), .HI_LIMIT(110)) u_c (
      .clk(clk), .rst(rst), .en(en_c), .sig_in(sig_c),
      .edge_cnt(c_cnt), .cnt_valid(c_valid), .freq_ok(c_ok), .no_clk(c_noclk), .busy(c_busy));

   initial forever #5 clk = ~clk;

   // Period 10 clk, toggling off the clk edges.
   initial begin
      sig_a = 1'b0;
      #3;
      forever begin
         #50;
         sig_a = sig_a_run ? ~sig_a : 1'b0;
      end
   end

   // Period 7 clk with a random start phase.
   initial begin
      sig_c = 1'b0;
      #(int'($urandom_range(0, 6)) * 10 + 2);
      forever #35 sig_c = ~sig_c;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic cur_valid(input int sel);
      case (sel)
         0:       return a_valid;
         1:       return b_valid;
         default: return c_valid;
      endcase
   endfunction

   task automatic wait_valid(input int sel, input int budget, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!cur_valid(sel) && cycles < budget);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      en_c = 1'b0;
      sig_a_run = 1'b1;

      step();
      step();
      chk("rst_edge_cnt", 32'(a_cnt), 0);
      chk("rst_cnt_valid", 32'(a_valid), 0);
      chk("rst_freq_ok", 32'(a_ok), 0);
      chk("rst_no_clk", 32'(a_noclk), 0);
      chk("rst_busy", 32'(a_busy), 0);

      rst = 1'b0;
      repeat (3) step();
      chk("idle_busy", 32'(a_busy), 0);
      chk("idle_valid", 32'(a_valid), 0);

      // First window: latency from en sampling to cnt_valid
      en_a = 1'b1;
      step();
      chk("start_busy", 32'(a_busy), 1);
      wait_valid(0, 1100, n);
      chk("first_latency", 32'(n + 1), 1002);
      chk("w1_edge_cnt", 32'(a_cnt), 100);
      chk("w1_freq_ok", 32'(a_ok), 1);
      chk("w1_no_clk", 32'(a_noclk), 0);
      step();
      chk("valid_pulse", 32'(a_valid), 0);
      chk("edge_hold", 32'(a_cnt), 100);

      wait_valid(0, 1100, n);
      chk("b2b_period", 32'(n + 1), 1002);
      chk("w2_edge_cnt", 32'(a_cnt), 100);

      // Stopped clock under test
      sig_a_run = 1'b0;
      wait_valid(0, 1100, n);
      chk("settle_period", 32'(n), 1002);
      wait_valid(0, 1100, n);
      chk("zero_period", 32'(n), 1002);
      chk("zero_edge_cnt", 32'(a_cnt), 0);
      chk("zero_no_clk", 32'(a_noclk), 1);
      chk("zero_freq_ok", 32'(a_ok), 0);

      sig_a_run = 1'b1;
      wait_valid(0, 1100, n);
      chk("resume_period", 32'(n), 1002);
      wait_valid(0, 1100, n);
      chk("w5_edge_cnt", 32'(a_cnt), 100);
      chk("w5_no_clk", 32'(a_noclk), 0);
      chk("w5_freq_ok", 32'(a_ok), 1);

      // Abort at gate cycle 500
      step();
      step();
      repeat (500) step();
      en_a = 1'b0;
      step();
      chk("abort_busy", 32'(a_busy), 0);
      seen = 1'b0;
      repeat (1100) begin
         step();
         if (a_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 0);
      chk("abort_edge_cnt", 32'(a_cnt), 100);
      chk("abort_freq_ok", 32'(a_ok), 1);

      // Reset at gate cycle 300
      en_a = 1'b1;
      repeat (302) step();
      chk("pre_rst_busy", 32'(a_busy), 1);
      rst = 1'b1;
      #1;
      chk("arst_edge_cnt", 32'(a_cnt), 0);
      chk("arst_freq_ok", 32'(a_ok), 0);
      chk("arst_busy", 32'(a_busy), 0);
      chk("arst_valid", 32'(a_valid), 0);
      en_a = 1'b0;
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("post_rst_idle", 32'(a_busy), 0);
      en_a = 1'b1;
      wait_valid(0, 1100, n);
      chk("post_rst_latency", 32'(n), 1002);
      chk("post_rst_edge_cnt", 32'(a_cnt), 100);
      chk("post_rst_freq_ok", 32'(a_ok), 1);
      en_a = 1'b0;

      // Saturating 4-bit counter
      en_b = 1'b1;
      wait_valid(1, 1100, n);
      chk("sat_latency", 32'(n), 1002);
      chk("sat_edge_cnt", 32'(b_cnt), 15);
      chk("sat_freq_ok", 32'(b_ok), 0);
      chk("sat_no_clk", 32'(b_noclk), 0);
      en_b = 1'b0;

      // Period 7 over a 700-cycle window
      en_c = 1'b1;
      wait_valid(2, 800, n);
      chk("p7_latency", 32'(n), 702);
      chk("p7_range_1", 32'(c_cnt >= 24'd99 && c_cnt <= 24'd101), 1);
      for (int w = 2; w <= 3; w++) begin
         wait_valid(2, 800, n);
         chk("p7_period", 32'(n), 702);
         chk("p7_range", 32'(c_cnt >= 24'd99 && c_cnt <= 24'd101), 1);
      end
      en_c = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
